// File: rtl/regfile_bypass.sv
// Multi-port register file with two write ports, write-through bypass,
// a per-register busy scoreboard, and a registered same-address write
// collision flag. Port B has priority over port A on a shared address.
module regfile_bypass #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]          rd_busy_o,
  input  logic                       wa_en_i,
  input  logic [ADDR_W-1:0]          wa_addr_i,
  input  logic [DATA_W-1:0]          wa_data_i,
  input  logic                       wb_en_i,
  input  logic [ADDR_W-1:0]          wb_addr_i,
  input  logic [DATA_W-1:0]          wb_data_i,
  input  logic                       rsv_en_i,
  input  logic [ADDR_W-1:0]          rsv_addr_i,
  output logic                       conflict_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic              conflict_q;

  logic wa_ok;
  logic wb_ok;
  logic rsv_ok;

  // Register 0 is hard-wired when ZERO_REG is set: it never stores,
  // never reserves and never takes part in a collision.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Qualify write/reserve enables against the hard-wired zero register.
  always_comb begin
    wa_ok  = wa_en_i  && !is_zero(wa_addr_i);
    wb_ok  = wb_en_i  && !is_zero(wb_addr_i);
    rsv_ok = rsv_en_i && !is_zero(rsv_addr_i);
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    logic wa_hit;
    logic wb_hit;
    logic rsv_hit;

    assign wa_hit  = wa_ok  && (wa_addr_i  == ADDR_W'(i));
    assign wb_hit  = wb_ok  && (wb_addr_i  == ADDR_W'(i));
    assign rsv_hit = rsv_ok && (rsv_addr_i == ADDR_W'(i));

    // Storage and busy bit for one register; B beats A, reservation beats clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        mem_q[i]  <= '0;
        busy_q[i] <= 1'b0;
      end else begin
        if (wb_hit) begin
          mem_q[i] <= wb_data_i;
        end else if (wa_hit) begin
          mem_q[i] <= wa_data_i;
        end
        if (rsv_hit) begin
          busy_q[i] <= 1'b1;
        end else if (wa_hit || wb_hit) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  // One-cycle pulse after both write ports hit the same real register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= wa_ok && wb_ok && (wa_addr_i == wb_addr_i);
    end
  end

  assign conflict_o = conflict_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              wa_m;
    logic              wb_m;
    logic              rsv_m;

    assign ra    = rd_addr_i[k*ADDR_W +: ADDR_W];
    assign wa_m  = wa_ok  && (wa_addr_i  == ra);
    assign wb_m  = wb_ok  && (wb_addr_i  == ra);
    assign rsv_m = rsv_ok && (rsv_addr_i == ra);

    // Combinational read with write-through bypass; reset forces zeros so
    // a write presented during reset cannot leak through the bypass path.
    always_comb begin
      data = mem_q[ra];
      busy = busy_q[ra];
      if (wb_m) begin
        data = wb_data_i;
      end else if (wa_m) begin
        data = wa_data_i;
      end
      if ((wa_m || wb_m) && !rsv_m) begin
        busy = 1'b0;
      end
      if (!rst_n_i || is_zero(ra)) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data_o[k*DATA_W +: DATA_W] = data;
    assign rd_busy_o[k]                  = busy;
  end

endmodule

// File: tb/tb_regfile_bypass.sv
// Bench for regfile_bypass: directed vector table, full-file reset check,
// then randomized traffic against a simple array-based reference model.
`timescale 1ns/1ps
module tb_regfile_bypass;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic             clk;
  logic             rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             wa_en;
  logic [AW-1:0]    wa_addr;
  logic [DW-1:0]    wa_data;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [DW-1:0]    wb_data;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic             conflict;

  regfile_bypass #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr),
    .conflict_o(conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [NR*DW-1:0] got, input logic [NR*DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Directed vector: inputs for one cycle plus expected same-cycle outputs.
  typedef struct {
    logic          wa_en;  logic [AW-1:0] wa_addr; logic [DW-1:0] wa_data;
    logic          wb_en;  logic [AW-1:0] wb_addr; logic [DW-1:0] wb_data;
    logic          rsv_en; logic [AW-1:0] rsv_addr;
    logic [AW-1:0] a0;     logic [AW-1:0] a1;
    logic [DW-1:0] d0;     logic [DW-1:0] d1;
    logic [1:0]    bsy;    logic          conf;
  } vec_t;

  function automatic vec_t mk(input logic wae, input int waa, input logic [DW-1:0] wad,
                              input logic wbe, input int wba, input logic [DW-1:0] wbd,
                              input logic rse, input int rsa, input int a0, input int a1,
                              input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic [1:0] bsy, input logic conf);
    vec_t v;
    v.wa_en = wae; v.wa_addr = AW'(waa); v.wa_data = wad;
    v.wb_en = wbe; v.wb_addr = AW'(wba); v.wb_data = wbd;
    v.rsv_en = rse; v.rsv_addr = AW'(rsa);
    v.a0 = AW'(a0); v.a1 = AW'(a1); v.d0 = d0; v.d1 = d1;
    v.bsy = bsy; v.conf = conf;
    return v;
  endfunction

  // Reference model state
  logic [DW-1:0] m_mem [32];
  bit            m_busy [32];
  bit            m_conf;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_conf = 1'b0;
  endtask

  function automatic logic [DW-1:0] p_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wb_en && wb_addr == a) return wb_data;
    if (wa_en && wa_addr == a) return wa_data;
    return m_mem[a];
  endfunction

  function automatic logic p_busy(input logic [AW-1:0] a);
    logic written;
    if (a == 0) return 1'b0;
    written = (wa_en && wa_addr == a) || (wb_en && wb_addr == a);
    if (written && !(rsv_en && rsv_addr == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_edge();
    if (wb_en && wb_addr != 0) m_mem[wb_addr] = wb_data;
    if (wa_en && wa_addr != 0 && !(wb_en && wb_addr == wa_addr)) m_mem[wa_addr] = wa_data;
    if (wa_en && wa_addr != 0) m_busy[wa_addr] = 1'b0;
    if (wb_en && wb_addr != 0) m_busy[wb_addr] = 1'b0;
    if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    m_conf = wa_en && wb_en && (wa_addr == wb_addr) && (wa_addr != 0);
  endtask

  task automatic idle_inputs();
    wa_en = 0; wa_addr = '0; wa_data = '0;
    wb_en = 0; wb_addr = '0; wb_data = '0;
    rsv_en = 0; rsv_addr = '0;
  endtask

  vec_t tv[$];
  logic [NR*DW-1:0] exp_d;
  logic [NR*DW-1:0] exp_b;

  initial begin
    // directed table, starting from a freshly reset file
    tv.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 7, 32'hDEADBEEF, 0, 2'b00, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 7, 32'hDEADBEEF, 0, 2'b00, 0));
    tv.push_back(mk(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 5, 7, 32'hDEADBEEF, 32'h22, 2'b00, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 7, 32'hDEADBEEF, 32'h22, 2'b00, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 7, 32'hDEADBEEF, 32'h22, 2'b00, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3, 3, 7, 0, 32'h22, 2'b00, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 7, 0, 32'h22, 2'b01, 0));
    tv.push_back(mk(0, 0, 0, 1, 3, 32'h55, 0, 0, 3, 7, 32'h55, 32'h22, 2'b00, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 7, 32'h55, 32'h22, 2'b00, 0));
    tv.push_back(mk(1, 9, 32'h1, 0, 0, 0, 1, 9, 9, 3, 32'h1, 32'h55, 2'b00, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 3, 32'h1, 32'h55, 2'b01, 0));
    tv.push_back(mk(1, 0, 32'hFFFFFFFF, 1, 0, 32'h12345678, 1, 0, 0, 0, 0, 0, 2'b00, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 32'h1, 2'b10, 0));
    tv.push_back(mk(1, 10, 32'hAA, 1, 11, 32'hBB, 0, 0, 10, 11, 32'hAA, 32'hBB, 2'b00, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 10, 11, 32'hAA, 32'hBB, 2'b00, 0));
    tv.push_back(mk(0, 0, 0, 1, 9, 32'h2, 0, 0, 9, 10, 32'h2, 32'hAA, 2'b00, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 10, 32'h2, 32'hAA, 2'b00, 0));

    // reset state, with a write presented that must not show through
    rst_n = 1'b0;
    idle_inputs();
    rd_addr = {5'd0, 5'd0, 5'd7, 5'd5};
    wa_en = 1; wa_addr = 5; wa_data = 32'hCAFEF00D;
    @(negedge clk); #1;
    chk("reset_data", rd_data, '0);
    chk("reset_busy", {{(NR*DW-NR){1'b0}}, rd_busy}, '0);
    chk("reset_conflict", {{(NR*DW-1){1'b0}}, conflict}, '0);
    #2;
    idle_inputs();
    rst_n = 1'b1;

    foreach (tv[i]) begin
      @(negedge clk);
      wa_en = tv[i].wa_en; wa_addr = tv[i].wa_addr; wa_data = tv[i].wa_data;
      wb_en = tv[i].wb_en; wb_addr = tv[i].wb_addr; wb_data = tv[i].wb_data;
      rsv_en = tv[i].rsv_en; rsv_addr = tv[i].rsv_addr;
      rd_addr = {5'd0, 5'd0, tv[i].a1, tv[i].a0};
      #1;
      chk($sformatf("vec%0d_data", i), rd_data, {64'h0, tv[i].d1, tv[i].d0});
      chk($sformatf("vec%0d_busy", i), {{(NR*DW-NR){1'b0}}, rd_busy}, {{(NR*DW-2){1'b0}}, tv[i].bsy});
      chk($sformatf("vec%0d_conflict", i), {{(NR*DW-1){1'b0}}, conflict}, {{(NR*DW-1){1'b0}}, tv[i].conf});
      @(posedge clk);
    end

    // fill 1..31 and reserve each, then reset asynchronously mid-cycle
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      idle_inputs();
      wa_en = 1; wa_addr = AW'(i); wa_data = 32'h1000 + i;
      rsv_en = 1; rsv_addr = AW'(i);
      @(posedge clk);
    end
    @(negedge clk);
    idle_inputs();
    rd_addr = {5'd5, 5'd16, 5'd1, 5'd31};
    #1;
    chk("fill_data", rd_data, {32'h1005, 32'h1010, 32'h1001, 32'h101F});
    chk("fill_busy", {{(NR*DW-NR){1'b0}}, rd_busy}, {{(NR*DW-NR){1'b0}}, 4'hF});
    #1;
    rst_n = 1'b0;
    wb_en = 1; wb_addr = 2; wb_data = 32'hBAD0BAD0;
    rsv_en = 1; rsv_addr = 2;
    for (int g = 0; g < 8; g++) begin
      rd_addr = {AW'(4*g+3), AW'(4*g+2), AW'(4*g+1), AW'(4*g)};
      #0.25;
      chk($sformatf("rst_grp%0d_data", g), rd_data, '0);
      chk($sformatf("rst_grp%0d_busy", g), {{(NR*DW-NR){1'b0}}, rd_busy}, '0);
    end
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rd_addr = {5'd0, 5'd31, 5'd1, 5'd2};
    #1;
    chk("post_rst_data", rd_data, '0);
    chk("post_rst_busy", {{(NR*DW-NR){1'b0}}, rd_busy}, '0);

    // randomized traffic against the reference model
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      rst_n = 1'b1;
      wa_en = ($urandom_range(0, 2) != 0); wa_addr = AW'($urandom_range(0, 7)); wa_data = $urandom;
      wb_en = ($urandom_range(0, 2) != 0); wb_addr = AW'($urandom_range(0, 7)); wb_data = $urandom;
      rsv_en = ($urandom_range(0, 2) == 0); rsv_addr = AW'($urandom_range(0, 7));
      for (int k = 0; k < NR; k++)
        rd_addr[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      #1;
      for (int k = 0; k < NR; k++) begin
        exp_d[k*DW +: DW] = p_data(rd_addr[k*AW +: AW]);
      end
      exp_b = '0;
      for (int k = 0; k < NR; k++) exp_b[k] = p_busy(rd_addr[k*AW +: AW]);
      chk($sformatf("rnd%0d_data", c), rd_data, exp_d);
      chk($sformatf("rnd%0d_busy", c), {{(NR*DW-NR){1'b0}}, rd_busy}, exp_b);
      chk($sformatf("rnd%0d_conflict", c), {{(NR*DW-1){1'b0}}, conflict}, {{(NR*DW-1){1'b0}}, m_conf});
      if ($urandom_range(0, 39) == 0) begin
        #1;
        rst_n = 1'b0;
        #1;
        chk($sformatf("rnd%0d_rst_data", c), rd_data, '0);
        chk($sformatf("rnd%0d_rst_conflict", c), {{(NR*DW-1){1'b0}}, conflict}, '0);
        model_clear();
        @(posedge clk);
      end else begin
        @(posedge clk);
        model_edge();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_bypass.md
REGFILE_BYPASS -- requirements
Module: regfile_bypass

Interface
REQ-001 Parameter DATA_W, default 32, data bits per register.
REQ-002 Parameter ADDR_W, default 5, address bits; depth = 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 4, number of read ports (1..8).
REQ-004 Parameter ZERO_REG, default 1; when 1, register 0 reads 0 and ignores writes and reservations.
REQ-005 Port clk_i input 1: the block's single clock; all state updates on its rising edge.
REQ-006 Port rst_n_i input 1: asynchronous, active-low reset.
REQ-007 Port rd_addr_i input NUM_RD*ADDR_W: read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-008 Port rd_data_o output NUM_RD*DATA_W: read data, same packing as rd_addr_i.
REQ-009 Port rd_busy_o output NUM_RD: scoreboard busy bit of each read address.
REQ-010 Ports wa_en_i in 1, wa_addr_i in ADDR_W, wa_data_i in DATA_W: write port A.
REQ-011 Ports wb_en_i in 1, wb_addr_i in ADDR_W, wb_data_i in DATA_W: write port B.
REQ-012 Ports rsv_en_i in 1, rsv_addr_i in ADDR_W: reserve a destination register (mark busy).
REQ-013 Port conflict_o output 1: registered one-cycle pulse reporting a same-address A/B write collision.

Function
REQ-014 Storage is 2**ADDR_W registers of DATA_W bits plus one busy bit per register.
REQ-015 Reads are combinational; zero cycles of latency from rd_addr_i to rd_data_o.
REQ-016 Write-through bypass: a read whose address matches an enabled write in the same cycle returns that write's data, not the stored value.
REQ-017 Write priority: when wa_en_i and wb_en_i target the same address, port B's data is written and bypassed, and port A's write is dropped.
REQ-018 A same-address collision sets conflict_o high for exactly the following cycle.
REQ-019 Writes to different addresses in the same cycle both take effect.
REQ-020 With ZERO_REG=1, reads of address 0 return 0 and rd_busy_o=0, bypass included; writes to address 0 cause no conflict pulse.
REQ-021 Scoreboard set: rsv_en_i sets busy[rsv_addr_i] on the clock edge.
REQ-022 Scoreboard clear: any enabled write clears busy[addr] on the clock edge.
REQ-023 When a reservation and a write hit the same address in one cycle, the reservation wins: the data is written and busy ends at 1.
REQ-024 rd_busy_o[k] reflects the stored busy bit, plus the same-cycle effect: it reads 0 if an enabled write matches with no same-address reservation.
REQ-025 A reservation alone does not bypass into rd_busy_o; it becomes visible in the cycle after the edge.
REQ-026 Out-of-range parameters are not required to be supported; NUM_RD=1 SHALL work.

Reset
REQ-027 Asserting rst_n_i low immediately clears all registers, all busy bits and conflict_o, without waiting for a clock edge.
REQ-028 While rst_n_i is low, all writes and reservations are ignored and rd_data_o reads 0 for every port.
REQ-029 Reset asserted mid-operation discards any in-flight write and reservation from that cycle.
REQ-030 The first edge after deassertion behaves as a normal cycle.

Verification
REQ-031 Reset, then write A to addr 5 with 0xDEADBEEF; the next cycle, read port 0 at addr 5 -> 0xDEADBEEF and busy=0.
REQ-032 In one cycle, A writes addr 7 with 0x11 and B writes addr 7 with 0x22, with port 1 reading addr 7 -> 0x22 the same cycle, 0x22 afterwards, and conflict_o=1 for one cycle only.
REQ-033 Reserve addr 3, then read addr 3 -> busy=1; B writes addr 3 with 0x55 -> read returns 0x55 with busy=0 the same cycle, and busy stays 0 afterwards.
REQ-034 Reserve addr 9 and write A to addr 9 with 0x1 in the same cycle -> the next cycle reads 0x1 with busy=1.
REQ-035 Write addr 0 with 0xFFFFFFFF and reserve addr 0 (ZERO_REG=1) -> all ports read 0 at addr 0, busy=0, and conflict_o=0.
REQ-036 After filling registers 1..31 with nonzero values, pulse rst_n_i low between clock edges -> all reads are 0 immediately and no busy bits are set.
